// File: rtl/count_capture.sv
// count_capture: debounced entry/exit/save/clear buttons, a saturating occupancy
// count, and a one-shot snapshot write into a DEPTH-entry stack whose fill
// level is mirrored locally from our writes and the consumer's reads.
module count_capture #(
  parameter int unsigned WIDTH           = 12,
  parameter int unsigned DEPTH           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_btn,
  input  logic             out_btn,
  input  logic             save_btn,
  input  logic             clear_btn,
  input  logic             read,
  output logic [WIDTH-1:0] count,
  output logic             write,
  output logic [2:0]       stored,
  output logic             full,
  output logic             err
);

  localparam int unsigned NBTN     = 4;
  localparam int unsigned DBW      = 8;
  localparam int unsigned SW       = 3;
  localparam int unsigned BTN_IN   = 0;
  localparam int unsigned BTN_OUT  = 1;
  localparam int unsigned BTN_SAVE = 2;
  localparam int unsigned BTN_CLR  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    HOLD = 2'd2
  } state_e;

  logic [NBTN-1:0]          raw_c;
  logic [NBTN-1:0]          sync1_q, sync2_q;
  logic [NBTN-1:0]          level_q, level_d;
  logic [NBTN-1:0]          level_dly_q;
  logic [NBTN-1:0]          pulse_q, pulse_d;
  logic [NBTN-1:0][DBW-1:0] db_cnt_q, db_cnt_d;

  // pending count events {clear, exit, entry} deferred while a push is in flight
  logic [2:0]       pend_q, pend_d;
  logic [2:0]       ev_c;
  logic [WIDTH-1:0] count_q, count_d;
  state_e           state_q, state_d;
  logic             write_q, write_d;
  logic [SW-1:0]    stored_q, stored_d;
  logic             err_q, err_d;
  logic             full_c;

  assign raw_c = {clear_btn, save_btn, out_btn, in_btn};

  // Two-flop synchroniser for the asynchronous button pins
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_c;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    level_d  = level_q;
    db_cnt_d = db_cnt_q;
    for (int unsigned i = 0; i < NBTN; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
        level_d[i]  = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
      end
    end
    pulse_d = level_q & ~level_dly_q;
  end

  // Debounce state, accepted level and registered rising-edge pulse
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      level_q     <= '0;
      level_dly_q <= '0;
      pulse_q     <= '0;
      db_cnt_q    <= '0;
    end else begin
      level_q     <= level_d;
      level_dly_q <= level_q;
      pulse_q     <= pulse_d;
      db_cnt_q    <= db_cnt_d;
    end
  end

  assign full_c = (stored_q == SW'(DEPTH));

  // Count update with clear > (entry & exit) > entry > exit; held off during PUSH
  always_comb begin
    count_d = count_q;
    pend_d  = '0;
    ev_c    = {pulse_q[BTN_CLR], pulse_q[BTN_OUT], pulse_q[BTN_IN]} | pend_q;
    if (state_q == PUSH) begin
      pend_d = ev_c;
    end else if (ev_c[2]) begin
      count_d = '0;
    end else if (ev_c[0] && !ev_c[1]) begin
      if (count_q != '1) count_d = count_q + WIDTH'(1);
    end else if (ev_c[1] && !ev_c[0]) begin
      if (count_q != '0) count_d = count_q - WIDTH'(1);
    end
  end

  // Save FSM next state, sticky error and push strobe
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (pulse_q[BTN_SAVE]) begin
          if (full_c) begin
            err_d   = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = PUSH;
          end
        end
      end
      PUSH: state_d = HOLD;
      HOLD: if (!level_q[BTN_SAVE]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    write_d = (state_d == PUSH);
  end

  // Fill mirror: our pushes against the consumer's pops
  always_comb begin
    stored_d = stored_q;
    if (write_q && !read) begin
      if (stored_q < SW'(DEPTH)) stored_d = stored_q + SW'(1);
    end else if (read && !write_q) begin
      if (stored_q != '0) stored_d = stored_q - SW'(1);
    end
  end

  // Count, FSM and mirror registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q  <= '0;
      pend_q   <= '0;
      state_q  <= IDLE;
      write_q  <= 1'b0;
      stored_q <= '0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      pend_q   <= pend_d;
      state_q  <= state_d;
      write_q  <= write_d;
      stored_q <= stored_d;
      err_q    <= err_d;
    end
  end

  assign count  = count_q;
  assign write  = write_q;
  assign stored = stored_q;
  assign full   = full_c;
  assign err    = err_q;

endmodule

// File: tb/tb_count_capture.sv
// Bench for count_capture: reset, latency, table-driven button sequences,
// multi-cycle corner cases, saturation on a narrow instance, and random
// button activity checked against an event-level model.
module tb_count_capture;

  localparam int unsigned WIDTH  = 12;
  localparam int unsigned DEPTH  = 5;
  localparam int          SETTLE = 14;

  localparam int OP_IN     = 0;
  localparam int OP_OUT    = 1;
  localparam int OP_GLITCH = 2;
  localparam int OP_SAVE   = 3;
  localparam int OP_READ   = 4;
  localparam int OP_CLEAR  = 5;
  localparam int OP_INOUT  = 6;
  localparam int OP_CLRIN  = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             nrst, in_btn, out_btn, save_btn, clear_btn, read;
  logic [WIDTH-1:0] count;
  logic             write, full, err;
  logic [2:0]       stored;

  logic       s_in;
  logic [3:0] s_count;
  logic       s_write, s_full, s_err;
  logic [2:0] s_stored;

  count_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEBOUNCE_CYCLES(4)) u_dut (
    .clk(clk), .nrst(nrst), .in_btn(in_btn), .out_btn(out_btn),
    .save_btn(save_btn), .clear_btn(clear_btn), .read(read),
    .count(count), .write(write), .stored(stored), .full(full), .err(err)
  );

  count_capture #(.WIDTH(4), .DEPTH(DEPTH), .DEBOUNCE_CYCLES(1)) u_sat (
    .clk(clk), .nrst(nrst), .in_btn(s_in), .out_btn(1'b0),
    .save_btn(1'b0), .clear_btn(1'b0), .read(1'b0),
    .count(s_count), .write(s_write), .stored(s_stored), .full(s_full), .err(s_err)
  );

  int errors = 0;
  int checks = 0;
  int wr_total = 0;
  int snap = -1;
  logic prev_wr = 1'b0;

  typedef struct {
    int op;
    int n;
    int hold;
    int exp_count;
    int exp_stored;
    int exp_err;
    int exp_wr;
    int exp_snap;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every write must be a single-cycle strobe; also record the snapshot value
  always @(negedge clk) begin
    if (write) begin
      checks++;
      if (prev_wr) begin
        errors++;
        $display("FAIL write_single: write high on consecutive cycles (t=%0t)", $time);
      end
      wr_total++;
      snap = int'(count);
    end
    prev_wr = write;
  end

  task automatic set_btn(input int op, input logic v);
    case (op)
      OP_IN:    in_btn = v;
      OP_OUT:   out_btn = v;
      OP_SAVE:  save_btn = v;
      OP_CLEAR: clear_btn = v;
      OP_INOUT: begin in_btn = v; out_btn = v; end
      OP_CLRIN: begin clear_btn = v; in_btn = v; end
      default:  in_btn = v;
    endcase
  endtask

  task automatic press(input int op, input int hold);
    @(negedge clk);
    set_btn(op, 1'b1);
    repeat (hold) @(negedge clk);
    set_btn(op, 1'b0);
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic do_op(input int op, input int hold, input int gbtn);
    case (op)
      OP_GLITCH: press(gbtn, hold);
      OP_READ: begin
        @(negedge clk);
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        repeat (2) @(negedge clk);
      end
      default: press(op, hold);
    endcase
  endtask

  task automatic wait_write(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (write) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_write: no write within 40 cycles (t=%0t)", $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    in_btn = 0; out_btn = 0; save_btn = 0; clear_btn = 0; read = 0; s_in = 0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_state(input string tag, input int c, input int s, input int e);
    chk({tag, "_count"}, int'(count), c);
    chk({tag, "_stored"}, int'(stored), s);
    chk({tag, "_full"}, int'(full), int'(s == int'(DEPTH)));
    chk({tag, "_err"}, int'(err), e);
  endtask

  initial begin
    bit ok;
    int w0, c0;
    int m_count, m_stored, m_err, op, hold, gb;

    vecs[0]  = '{OP_IN,     2, 20, 3, 0, 0, 0, 0};
    vecs[1]  = '{OP_GLITCH, 1,  3, 3, 0, 0, 0, 0};
    vecs[2]  = '{OP_OUT,    1, 20, 2, 0, 0, 0, 0};
    vecs[3]  = '{OP_OUT,    5, 20, 0, 0, 0, 0, 0};
    vecs[4]  = '{OP_IN,     9, 10, 9, 0, 0, 0, 0};
    vecs[5]  = '{OP_SAVE,   1, 30, 9, 1, 0, 1, 9};
    vecs[6]  = '{OP_SAVE,   1, 20, 9, 2, 0, 1, 9};
    vecs[7]  = '{OP_INOUT,  1, 15, 9, 2, 0, 0, 0};
    vecs[8]  = '{OP_SAVE,   3, 12, 9, 5, 0, 3, 9};
    vecs[9]  = '{OP_SAVE,   1, 12, 9, 5, 1, 0, 0};
    vecs[10] = '{OP_READ,   1,  1, 9, 4, 1, 0, 0};
    vecs[11] = '{OP_IN,     1, 12, 10, 4, 1, 0, 0};
    vecs[12] = '{OP_CLRIN,  1, 15, 0, 4, 1, 0, 0};

    // Reset with all buttons high: every output cleared
    nrst = 1'b0;
    in_btn = 1; out_btn = 1; save_btn = 1; clear_btn = 1; read = 0; s_in = 0;
    #23;
    chk("rst_count", int'(count), 0);
    chk("rst_write", int'(write), 0);
    chk("rst_stored", int'(stored), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_err", int'(err), 0);
    in_btn = 0; out_btn = 0; save_btn = 0; clear_btn = 0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);

    // First entry press: count still 0 after edge N+6, becomes 1 after edge N+7
    in_btn = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("lat_before", int'(count), 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_after", int'(count), 1);
    repeat (12) @(negedge clk);
    in_btn = 1'b0;
    repeat (SETTLE) @(negedge clk);

    // Table-driven sequences
    foreach (vecs[k]) begin
      w0 = wr_total;
      for (int r = 0; r < vecs[k].n; r++) do_op(vecs[k].op, vecs[k].hold, OP_IN);
      chk_state($sformatf("vec%0d", k), vecs[k].exp_count, vecs[k].exp_stored, vecs[k].exp_err);
      chk($sformatf("vec%0d_writes", k), wr_total - w0, vecs[k].exp_wr);
      if (vecs[k].exp_wr > 0) chk($sformatf("vec%0d_snap", k), snap, vecs[k].exp_snap);
    end

    // Reset clears the sticky error; build count 4, stored 3
    do_reset();
    chk("err_cleared", int'(err), 0);
    for (int r = 0; r < 4; r++) press(OP_IN, 10);
    for (int r = 0; r < 3; r++) press(OP_SAVE, 12);
    chk_state("pre_rw", 4, 3, 0);

    // Read coinciding with write at stored 3
    w0 = wr_total;
    @(negedge clk);
    save_btn = 1'b1;
    wait_write(ok);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    repeat (10) @(negedge clk);
    save_btn = 1'b0;
    repeat (SETTLE) @(negedge clk);
    chk("rw_stored", int'(stored), 3);
    chk("rw_writes", wr_total - w0, 1);

    // Entry pulse landing in PUSH: snapshot keeps old count, increment follows
    c0 = int'(count);
    @(negedge clk);
    save_btn = 1'b1;
    @(negedge clk);
    in_btn = 1'b1;
    wait_write(ok);
    chk("push_snap", int'(count), c0);
    @(negedge clk);
    chk("push_defer", int'(count), c0);
    @(negedge clk);
    chk("push_applied", int'(count), c0 + 1);
    repeat (10) @(negedge clk);
    save_btn = 1'b0;
    in_btn = 1'b0;
    repeat (SETTLE) @(negedge clk);
    chk_state("post_push", c0 + 1, 4, 0);

    // Reset asserted while write is high
    @(negedge clk);
    save_btn = 1'b1;
    wait_write(ok);
    #1 nrst = 1'b0;
    #1;
    chk("midrst_write", int'(write), 0);
    chk("midrst_stored", int'(stored), 0);
    chk("midrst_count", int'(count), 0);
    save_btn = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (SETTLE) @(negedge clk);
    chk("midrst_nowrite", int'(write), 0);

    // Saturation at the top of a 4-bit count (single-sample debounce)
    for (int r = 0; r < 17; r++) begin
      @(negedge clk);
      s_in = 1'b1;
      repeat (4) @(negedge clk);
      s_in = 1'b0;
      repeat (6) @(negedge clk);
    end
    chk("sat_count", int'(s_count), 15);

    // Random button activity against an event-level model
    do_reset();
    m_count = 0; m_stored = 0; m_err = 0;
    for (int t = 0; t < 60; t++) begin
      op   = int'($urandom_range(0, 6));
      hold = int'($urandom_range(6, 20));
      gb   = int'($urandom_range(0, 3));
      if (op == 6) op = OP_IN;
      if (op == OP_GLITCH) hold = int'($urandom_range(1, 3));
      w0 = wr_total;
      do_op(op, hold, gb);
      case (op)
        OP_IN:    if (m_count < 4095) m_count++;
        OP_OUT:   if (m_count > 0) m_count--;
        OP_CLEAR: m_count = 0;
        OP_READ:  if (m_stored > 0) m_stored--;
        OP_SAVE: begin
          if (m_stored == int'(DEPTH)) begin
            m_err = 1;
            chk($sformatf("rnd%0d_writes", t), wr_total - w0, 0);
          end else begin
            m_stored++;
            chk($sformatf("rnd%0d_writes", t), wr_total - w0, 1);
            chk($sformatf("rnd%0d_snap", t), snap, m_count);
          end
        end
        default: ;
      endcase
      chk_state($sformatf("rnd%0d", t), m_count, m_stored, m_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound
  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
